ping_pong_out_ctrl: RTL and testbench

// Drain-side controller paired with the input ping-pong controller. It collects result blocks from the

---
 rtl/ping_pong_out_ctrl.sv | 142 ++++++++++++++
 tb/tb_ping_pong_out_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ping_pong_out_ctrl.sv
// Drain-side ping-pong controller: fills two result banks alternately and streams each full bank
// to the consumer as one row of COL_Y words. The bank RAMs (1-cycle read latency) sit outside.
module ping_pong_out_ctrl #(
  parameter int COL_Y      = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_ROWS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  res_valid,
  output logic                  res_ready,
  output logic                  bank0_en,
  output logic                  bank0_we,
  output logic [ADDR_WIDTH-1:0] bank0_addr,
  output logic                  bank1_en,
  output logic                  bank1_we,
  output logic [ADDR_WIDTH-1:0] bank1_addr,
  output logic                  rd_bank_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  done,
  output logic                  state_now
);

  localparam int ROW_W = $clog2(NUM_ROWS + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(COL_Y - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(NUM_ROWS - 1);

  // Handshakes (res_valid/res_ready, out_valid/out_ready): a transfer occurs on every cycle where
  // both are high; out_valid, once raised, holds until its word is accepted (or rst).
  typedef enum logic [1:0] {RD_IDLE, RD_PRIME, RD_STREAM} rd_phase_t;

  rd_phase_t             phase, phase_nxt;
  logic                  wr_sel, rd_sel;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr, rd_ram_addr;
  logic [1:0]            bank_full, bank_full_nxt;
  logic [ROW_W-1:0]      rows;
  logic                  done_q;
  logic                  wr_fire, wr_last, ov, last_word, rd_fire, rd_done;
  logic                  rd_own0, rd_own1;

  assign res_ready   = ~rst & ~done_q & ~bank_full[wr_sel];
  assign wr_fire     = res_valid & res_ready;
  assign wr_last     = wr_fire & (wr_addr == LAST_ADDR);
  assign ov          = (phase == RD_STREAM);
  assign last_word   = ov & (rd_addr == LAST_ADDR);
  assign rd_fire     = ov & out_ready;
  assign rd_done     = rd_fire & last_word;
  // Advance the RAM address only when the presented word is taken, so a stall re-reads it.
  assign rd_ram_addr = (rd_fire & ~last_word) ? rd_addr + ADDR_WIDTH'(1) : rd_addr;

  always_comb begin
    phase_nxt = phase;
    case (phase)
      // A bank completing this cycle on the read side starts priming immediately.
      RD_IDLE:   if (~done_q & (bank_full[rd_sel] | (wr_last & (wr_sel == rd_sel))))
                   phase_nxt = RD_PRIME;
      RD_PRIME:  phase_nxt = RD_STREAM;
      RD_STREAM: if (rd_done) phase_nxt = RD_IDLE;
      default:   phase_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_last) bank_full_nxt[wr_sel] = 1'b1;
    if (rd_done) bank_full_nxt[rd_sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= RD_IDLE;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      bank_full <= 2'b00;
      rows      <= '0;
      done_q    <= 1'b0;
    end else begin
      phase     <= phase_nxt;
      bank_full <= bank_full_nxt;
      if (wr_fire) begin
        if (wr_last) begin
          wr_sel  <= ~wr_sel;
          wr_addr <= '0;
        end else begin
          wr_addr <= wr_addr + ADDR_WIDTH'(1);
        end
      end
      if (rd_fire) begin
        if (last_word) begin
          rd_sel  <= ~rd_sel;
          rd_addr <= '0;
          rows    <= rows + ROW_W'(1);
          if (rows == LAST_ROW) done_q <= 1'b1;
        end else begin
          rd_addr <= rd_addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // The read side owns its bank while priming or streaming; the write side owns it otherwise.
  assign rd_own0 = ~rd_sel & (phase != RD_IDLE);
  assign rd_own1 =  rd_sel & (phase != RD_IDLE);

  always_comb begin
    bank0_en   = 1'b0;
    bank0_we   = 1'b0;
    bank0_addr = '0;
    bank1_en   = 1'b0;
    bank1_we   = 1'b0;
    bank1_addr = '0;
    if (!rst) begin
      if (rd_own0) begin
        bank0_en   = 1'b1;
        bank0_addr = rd_ram_addr;
      end else if (~wr_sel) begin
        bank0_en   = wr_fire;
        bank0_we   = wr_fire;
        bank0_addr = wr_addr;
      end
      if (rd_own1) begin
        bank1_en   = 1'b1;
        bank1_addr = rd_ram_addr;
      end else if (wr_sel) begin
        bank1_en   = wr_fire;
        bank1_we   = wr_fire;
        bank1_addr = wr_addr;
      end
    end
  end

  assign rd_bank_sel = ~rst & rd_sel;
  assign out_valid   = ~rst & ov;
  assign out_last    = ~rst & last_word;
  assign done        = ~rst & done_q;
  assign state_now   = ~rst & wr_sel;

endmodule

// File: tb/tb_ping_pong_out_ctrl.sv
// Bench for ping_pong_out_ctrl: RAM models for both banks, a row-level reference model with an
// expected-data queue, directed scenarios with literal expectations, then randomized traffic.
module tb_ping_pong_out_ctrl;
  localparam int COL_Y      = 4;
  localparam int ADDR_WIDTH = 2;
  localparam int NUM_ROWS   = 6;
  localparam int DW         = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  res_valid, res_ready;
  logic                  bank0_en, bank0_we, bank1_en, bank1_we;
  logic [ADDR_WIDTH-1:0] bank0_addr, bank1_addr;
  logic                  rd_bank_sel, out_valid, out_ready, out_last, done, state_now;
  logic [DW-1:0]         wr_data, dout0, dout1, out_data;
  logic [DW-1:0]         mem0 [0:(1<<ADDR_WIDTH)-1];
  logic [DW-1:0]         mem1 [0:(1<<ADDR_WIDTH)-1];

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_done, m_full, m_wr_bank, m_wr_cnt, m_streaming, m_word, m_rd_bank, m_rows, m_last_end;
  int cyc = 0;
  int avail_q[$];
  logic [DW-1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  ping_pong_out_ctrl #(.COL_Y(COL_Y), .ADDR_WIDTH(ADDR_WIDTH), .NUM_ROWS(NUM_ROWS)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
    .bank0_en(bank0_en), .bank0_we(bank0_we), .bank0_addr(bank0_addr),
    .bank1_en(bank1_en), .bank1_we(bank1_we), .bank1_addr(bank1_addr),
    .rd_bank_sel(rd_bank_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .done(done), .state_now(state_now)
  );

  // external single-port bank RAMs, 1-cycle read latency
  always @(posedge clk) begin
    if (bank0_en) begin
      if (bank0_we) mem0[bank0_addr] <= wr_data;
      else          dout0 <= mem0[bank0_addr];
    end
    if (bank1_en) begin
      if (bank1_we) mem1[bank1_addr] <= wr_data;
      else          dout1 <= mem1[bank1_addr];
    end
  end
  assign out_data = rd_bank_sel ? dout1 : dout0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    m_done = 0; m_full = 0; m_wr_bank = 0; m_wr_cnt = 0;
    m_streaming = 0; m_word = 0; m_rd_bank = 0; m_rows = 0; m_last_end = -10;
    avail_q.delete();
    exp_q.delete();
  endtask

  // One clock cycle: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    logic exp_rr, acc_w, acc_r;
    int   exp_addr;
    @(negedge clk);
    if (rst) begin
      chk("rst_res_ready", res_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_done", done, 0);
      chk("rst_state_now", state_now, 0);
      chk("rst_bank_en", {bank0_en, bank1_en}, 0);
      model_reset();
    end else begin
      // a completed row streams 2 cycles after its last write, and no sooner than 3 after the previous row ended
      if (!m_streaming && !m_done && avail_q.size() > 0 && cyc >= avail_q[0] && cyc >= m_last_end + 3) begin
        m_streaming = 1;
        m_word = 0;
        void'(avail_q.pop_front());
      end
      exp_rr = (m_done == 0) && (m_full < 2);
      acc_w  = res_valid && exp_rr;
      acc_r  = (m_streaming != 0) && out_ready;
      chk("res_ready", res_ready, exp_rr);
      chk("out_valid", out_valid, m_streaming);
      chk("out_last", out_last, (m_streaming != 0) && (m_word == COL_Y - 1));
      chk("done", done, m_done);
      chk("state_now", state_now, m_wr_bank);
      chk("bank0_we", bank0_we, acc_w && (m_wr_bank == 0));
      chk("bank1_we", bank1_we, acc_w && (m_wr_bank == 1));
      if (acc_w) chk("wr_addr", m_wr_bank ? bank1_addr : bank0_addr, m_wr_cnt);
      if (m_streaming != 0) begin
        exp_addr = (out_ready && m_word != COL_Y - 1) ? m_word + 1 : m_word;
        chk("rd_bank_sel", rd_bank_sel, m_rd_bank);
        chk("rd_en", m_rd_bank ? bank1_en : bank0_en, 1);
        chk("rd_addr", m_rd_bank ? bank1_addr : bank0_addr, exp_addr);
      end
      if (acc_r) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL out_data: word accepted with no expected data (cycle %0d)", cyc);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end
      if (acc_w) begin
        exp_q.push_back(wr_data);
        m_wr_cnt++;
        if (m_wr_cnt == COL_Y) begin
          m_wr_cnt = 0;
          m_wr_bank ^= 1;
          m_full++;
          avail_q.push_back(cyc + 2);
        end
      end
      if (acc_r) begin
        if (m_word == COL_Y - 1) begin
          m_streaming = 0;
          m_last_end = cyc;
          m_full--;
          m_rd_bank ^= 1;
          m_rows++;
          if (m_rows == NUM_ROWS) m_done = 1;
        end else begin
          m_word++;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; res_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int n_acc;
    rst = 1'b1; res_valid = 1'b0; out_ready = 1'b0; wr_data = '0;
    model_reset();
    @(posedge clk);
    #1;

    // reset state
    do_reset();
    chk("lit_reset_res_ready", res_ready, 1);
    chk("lit_reset_out_valid", out_valid, 0);
    chk("lit_reset_state_now", state_now, 0);

    // one row through bank0, out_valid two cycles after the fourth beat
    for (int i = 0; i < COL_Y; i++) begin
      res_valid = 1'b1; wr_data = DW'(16'h00A0 + i);
      tick();
    end
    res_valid = 1'b0; out_ready = 1'b1; #1;
    chk("lit_t1_not_yet_valid", out_valid, 0);
    chk("lit_t1_wr_bank", state_now, 1);
    tick();
    for (int i = 0; i < COL_Y; i++) begin
      chk("lit_t1_valid", out_valid, 1);
      chk("lit_t1_data", out_data, 16'h00A0 + i);
      chk("lit_t1_last", out_last, (i == COL_Y - 1));
      tick();
    end
    chk("lit_t1_drained", out_valid, 0);

    // stall at word 1 of the bank1 row
    for (int i = 0; i < COL_Y; i++) begin
      res_valid = 1'b1; wr_data = DW'(16'h00B0 + i);
      tick();
    end
    res_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b0; #1;
    for (int k = 0; k < 5; k++) begin
      chk("lit_t2_stall_valid", out_valid, 1);
      chk("lit_t2_stall_addr", bank1_addr, 1);
      chk("lit_t2_stall_data", out_data, 16'h00B1);
      tick();
    end
    out_ready = 1'b1; #1;
    for (int i = 1; i < COL_Y; i++) begin
      chk("lit_t2_data", out_data, 16'h00B0 + i);
      tick();
    end
    chk("lit_t2_rd_bank", rd_bank_sel, 0);

    // both banks fill while the consumer stalls, then drain
    do_reset();
    res_valid = 1'b1; out_ready = 1'b0; n_acc = 0;
    for (int k = 0; k < 14; k++) begin
      wr_data = DW'($urandom);
      #1;
      if (res_ready) n_acc++;
      tick();
    end
    chk("lit_t3_accepts", n_acc, 8);
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      wr_data = DW'($urandom);
      tick();
    end
    res_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick();

    // bank1 completes in the same cycle bank0 delivers its last word
    do_reset();
    for (int i = 0; i < 2 * COL_Y - 1; i++) begin
      res_valid = 1'b1; wr_data = DW'(16'h00C0 + i);
      tick();
    end
    res_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < COL_Y - 1; i++) tick();
    res_valid = 1'b1; wr_data = 16'h00C7; #1;
    chk("lit_t4_last_word", out_last, 1);
    tick();
    res_valid = 1'b0; #1;
    chk("lit_t4_rd_bank", rd_bank_sel, 1);
    chk("lit_t4_wr_bank", state_now, 0);
    for (int k = 0; k < 10; k++) tick();

    // reset in the middle of a row
    do_reset();
    for (int i = 0; i < COL_Y; i++) begin
      res_valid = 1'b1; wr_data = DW'(16'h00D0 + i);
      tick();
    end
    res_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("lit_t6_word2", out_data, 16'h00D2);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("lit_t6_out_valid", out_valid, 0);
    chk("lit_t6_res_ready", res_ready, 1);
    for (int k = 0; k < 4; k++) tick();
    chk("lit_t6_no_stale_row", out_valid, 0);

    // randomized traffic with occasional resets
    for (int ep = 0; ep < 5; ep++) begin
      do_reset();
      for (int k = 0; k < 300; k++) begin
        rst       = ($urandom_range(0, 199) == 0);
        res_valid = ($urandom_range(0, 3) < 3 - (ep % 3));
        out_ready = ($urandom_range(0, 3) >= (ep % 2) * 2);
        wr_data   = DW'($urandom);
        tick();
      end
    end

    // run to done: further rows are blocked
    do_reset();
    for (int k = 0; k < 150; k++) begin
      res_valid = 1'b1;
      out_ready = ($urandom_range(0, 3) != 0);
      wr_data   = DW'($urandom);
      tick();
    end
    chk("lit_t5_done", done, 1);
    chk("lit_t5_res_ready", res_ready, 0);
    chk("lit_t5_out_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
